// File: rtl/sd_card_detect_pkg.sv
// Shared encodings for the SD card-detect block: CD presence FSM states and
// irq bit positions used by irq_en / irq_clear / irq_status.
package sd_card_detect_pkg;

  typedef enum logic [1:0] {
    ABSENT      = 2'd0,
    INSERT_WAIT = 2'd1,
    PRESENT     = 2'd2,
    REMOVE_WAIT = 2'd3
  } cd_state_e;

  localparam int IRQ_INSERT = 0;
  localparam int IRQ_REMOVE = 1;

endpackage

// File: rtl/sd_debounce_filter.sv
// Stable-level filter: dout follows din only after DEBOUNCE_CYCLES consecutive
// differing samples; accept flags the edge at which dout will flip.
module sd_debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_WIDTH       = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic accept
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT  = '1;

  logic [CNT_WIDTH-1:0] cnt;

  always_comb accept = (din != dout) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt  <= '0;
    end else if (accept) begin
      dout <= din;
      cnt  <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_card_detect.sv
// SD socket card-detect / write-protect conditioning: debounced presence FSM,
// insert/remove pulses and a sticky, maskable interrupt.
module sd_card_detect
  import sd_card_detect_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_WIDTH       = 17,
  parameter bit CD_ACTIVE_LOW   = 1'b1,
  parameter bit WP_ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cd_sync,
  input  logic       wp_sync,
  input  logic [1:0] irq_en,
  input  logic [1:0] irq_clear,
  output logic       card_present,
  output logic       card_wp,
  output logic       card_inserted,
  output logic       card_removed,
  output logic [1:0] irq_status,
  output logic       irq
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be 2 or more");
  end
  if ((64'd1 << CNT_WIDTH) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_width
    $error("CNT_WIDTH too narrow for DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT  = '1;

  logic cd_act, wp_act;
  assign cd_act = cd_sync ^ CD_ACTIVE_LOW;
  assign wp_act = wp_sync ^ WP_ACTIVE_LOW;

  cd_state_e            state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 ins_nxt, rem_nxt, present_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ins_nxt   = 1'b0;
    rem_nxt   = 1'b0;
    unique case (state)
      ABSENT: begin
        if (cd_act) begin
          state_nxt = INSERT_WAIT;
          cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      INSERT_WAIT: begin
        if (!cd_act) begin
          state_nxt = ABSENT;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESENT;
          cnt_nxt   = '0;
          ins_nxt   = 1'b1;
        end else if (cnt != CNT_SAT) begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      PRESENT: begin
        if (!cd_act) begin
          state_nxt = REMOVE_WAIT;
          cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      REMOVE_WAIT: begin
        if (cd_act) begin
          state_nxt = PRESENT;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ABSENT;
          cnt_nxt   = '0;
          rem_nxt   = 1'b1;
        end else if (cnt != CNT_SAT) begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ABSENT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign present_nxt = (state_nxt == PRESENT) || (state_nxt == REMOVE_WAIT);

  // WP filter; card_wp is built from its next value so it tracks card_present
  logic wp_deb, wp_accept, wp_deb_nxt;

  sd_debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_wp_filter (
    .clk   (clk),
    .rst   (rst),
    .din   (wp_act),
    .dout  (wp_deb),
    .accept(wp_accept)
  );

  assign wp_deb_nxt = wp_accept ? ~wp_deb : wp_deb;

  logic [1:0] evt_nxt, status_nxt;

  always_comb begin
    evt_nxt             = '0;
    evt_nxt[IRQ_INSERT] = ins_nxt;
    evt_nxt[IRQ_REMOVE] = rem_nxt;
    // a new event wins over a clear strobe in the same cycle
    status_nxt          = evt_nxt | (irq_status & ~irq_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ABSENT;
      cnt           <= '0;
      card_present  <= 1'b0;
      card_wp       <= 1'b0;
      card_inserted <= 1'b0;
      card_removed  <= 1'b0;
      irq_status    <= 2'b00;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      card_present  <= present_nxt;
      card_wp       <= wp_deb_nxt & present_nxt;
      card_inserted <= ins_nxt;
      card_removed  <= rem_nxt;
      irq_status    <= status_nxt;
    end
  end

  assign irq = |(irq_status & irq_en);

endmodule

// File: tb/tb_sd_card_detect.sv
// Self-checking bench for sd_card_detect: directed scenarios plus random
// socket activity, compared each cycle against a run-length reference model.
module tb_sd_card_detect;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst, cd_sync, wp_sync;
  logic [1:0] irq_en, irq_clear;
  logic       card_present, card_wp, card_inserted, card_removed, irq;
  logic [1:0] irq_status;

  always #5 clk = ~clk;

  sd_card_detect #(
    .DEBOUNCE_CYCLES(N),
    .CNT_WIDTH      (4),
    .CD_ACTIVE_LOW  (1'b1),
    .WP_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cd_sync      (cd_sync),
    .wp_sync      (wp_sync),
    .irq_en       (irq_en),
    .irq_clear    (irq_clear),
    .card_present (card_present),
    .card_wp      (card_wp),
    .card_inserted(card_inserted),
    .card_removed (card_removed),
    .irq_status   (irq_status),
    .irq          (irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted after N consecutive samples that
  // differ from the currently accepted level.
  logic       m_pres, m_wp, m_cwp, m_ins, m_rem;
  logic [1:0] m_stat;
  int         run_cd, run_wp;

  task automatic model_step();
    logic cd_a, wp_a;
    if (rst) begin
      m_pres = 0; m_wp = 0; m_cwp = 0; m_ins = 0; m_rem = 0;
      m_stat = 2'b00; run_cd = 0; run_wp = 0;
    end else begin
      cd_a  = ~cd_sync;
      wp_a  = wp_sync;
      m_ins = 0;
      m_rem = 0;
      if (cd_a != m_pres) begin
        run_cd++;
        if (run_cd == N) begin
          m_pres = cd_a;
          run_cd = 0;
          if (cd_a) m_ins = 1; else m_rem = 1;
        end
      end else run_cd = 0;
      if (wp_a != m_wp) begin
        run_wp++;
        if (run_wp == N) begin
          m_wp   = wp_a;
          run_wp = 0;
        end
      end else run_wp = 0;
      m_stat = {m_rem, m_ins} | (m_stat & ~irq_clear);
      m_cwp  = m_wp & m_pres;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("card_present",  card_present,  m_pres);
    chk("card_wp",       card_wp,       m_cwp);
    chk("card_inserted", card_inserted, m_ins);
    chk("card_removed",  card_removed,  m_rem);
    chk("irq_status",    irq_status,    m_stat);
    chk("irq",           irq,           |(m_stat & irq_en));
  endtask

  task automatic hold(input logic cd, input logic wp, input int n);
    cd_sync = cd;
    wp_sync = wp;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1; cd_sync = 1; wp_sync = 0; irq_en = 2'b01; irq_clear = 2'b00;
    cycle(); cycle();
    chk("reset_present", card_present, 1'b0);
    chk("reset_status",  irq_status,   2'b00);
    chk("reset_irq",     irq,          1'b0);
    rst = 0;

    // insertion accepted on the cycle after the 8th low sample
    hold(1'b0, 1'b0, N - 1);
    chk("t1_not_yet", card_present, 1'b0);
    hold(1'b0, 1'b0, 1);
    chk("t1_present", card_present, 1'b1);
    chk("t1_pulse",   card_inserted, 1'b1);
    chk("t1_status",  irq_status, 2'b01);
    chk("t1_irq",     irq, 1'b1);
    hold(1'b0, 1'b0, 1);
    chk("t1_pulse_end", card_inserted, 1'b0);

    // 7-cycle removal glitch rejected
    hold(1'b1, 1'b0, N - 1);
    hold(1'b0, 1'b0, 3);
    chk("t2_present", card_present, 1'b1);
    chk("t2_status",  irq_status, 2'b01);

    // write-protect then removal
    irq_en = 2'b11;
    hold(1'b0, 1'b1, N);
    chk("t3_wp", card_wp, 1'b1);
    hold(1'b1, 1'b1, N);
    chk("t3_removed", card_removed, 1'b1);
    chk("t3_present", card_present, 1'b0);
    chk("t3_wp_drop", card_wp, 1'b0);
    chk("t3_status",  irq_status, 2'b11);

    // clear coincident with insert pulse loses; later clear wins
    hold(1'b0, 1'b0, N - 1);
    irq_clear = 2'b01;
    hold(1'b0, 1'b0, 1);
    chk("t4_set_wins", irq_status[0], 1'b1);
    irq_clear = 2'b00;
    hold(1'b0, 1'b0, 1);
    irq_clear = 2'b01;
    hold(1'b0, 1'b0, 1);
    chk("t4_cleared", irq_status[0], 1'b0);
    irq_clear = 2'b00;

    // reset mid-INSERT_WAIT restarts the debounce
    hold(1'b1, 1'b0, N);
    irq_clear = 2'b11;
    hold(1'b1, 1'b0, 1);
    irq_clear = 2'b00;
    hold(1'b0, 1'b0, 5);
    rst = 1;
    hold(1'b0, 1'b0, 1);
    chk("t5_no_pulse", card_inserted, 1'b0);
    rst = 0;
    hold(1'b0, 1'b0, N - 1);
    chk("t5_restart", card_present, 1'b0);
    hold(1'b0, 1'b0, 1);
    chk("t5_accept", card_present, 1'b1);

    // masked interrupts still record status
    irq_clear = 2'b11;
    hold(1'b0, 1'b0, 1);
    irq_clear = 2'b00;
    irq_en = 2'b00;
    hold(1'b1, 1'b0, N);
    hold(1'b0, 1'b0, N);
    chk("t6_status", irq_status, 2'b11);
    chk("t6_irq_masked", irq, 1'b0);
    irq_en = 2'b10;
    #1;
    chk("t6_irq_comb", irq, 1'b1);

    // random socket activity with bounces of varying length
    for (int k = 0; k < 300; k++) begin
      logic c, w;
      int   len;
      c         = 1'($urandom_range(0, 1));
      w         = 1'($urandom_range(0, 1));
      len       = $urandom_range(1, 12);
      irq_en    = 2'($urandom_range(0, 3));
      irq_clear = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rst       = ($urandom_range(0, 40) == 0);
      hold(c, w, 1);
      irq_clear = 2'b00;
      rst       = 0;
      hold(c, w, len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
